// File: rtl/bcsa_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : bcsa_pipe_if
// Description : Handshake and data bundle for the bcsa_pipe speculative adder.
//               Producer side: in_valid/in_ready, a, b, mode.
//               Consumer side: out_valid/out_ready, sum, err, err_mask, err_cnt.
//               master = the environment driving operands and accepting
//               results; slave = the adder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcsa_pipe_if #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int CNT_W = 16
);
  localparam int NBLK = WIDTH / BLK;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     sum;
  logic               err;
  logic [NBLK-2:0]    err_mask;
  logic [CNT_W-1:0]   err_cnt;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, err, err_mask, err_cnt
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, err, err_mask, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bcsa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bcsa_pipe
// Description : Registered block-based carry-speculative adder. WIDTH-bit
//               operands are split into NBLK = WIDTH/BLK blocks; each block's
//               carry-in is predicted from a LOOK-bit window just below it.
//               mode = 0 returns the speculative sum, mode = 1 replaces it by
//               the exact sum when any prediction was wrong (one extra cycle).
// Ports       : clk      - clock, rising edge
//               rst_n    - synchronous active-low reset
//               bus      - bcsa_pipe_if.slave (operand/result handshakes,
//                          sum, err, err_mask, saturating err_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module bcsa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int LOOK  = 4,
  parameter int CNT_W = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  bcsa_pipe_if.slave  bus
);
  localparam int NBLK = WIDTH / BLK;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_CORR = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        r_state;
  logic              r_in_ready;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_mode;
  logic [WIDTH:0]    r_sum;
  logic              r_err;
  logic [NBLK-2:0]   r_err_mask;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [NBLK-1:0]   w_pc;      // predicted carry into each block
  logic [NBLK-1:1]   w_ec;      // exact carry into each block
  logic [WIDTH:0]    w_approx;
  logic [WIDTH:0]    w_exact;
  logic [NBLK-2:0]   w_mask;
  logic              w_err;

  assign w_exact = {1'b0, r_a} + {1'b0, r_b};
  assign w_pc[0] = 1'b0;

  generate
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
      if (k > 0) begin : g_pred
        // Window is clipped so it never reaches below bit 0.
        localparam int L = (LOOK < k * BLK) ? LOOK : k * BLK;
        assign w_pc[k] = 1'(({1'b0, r_a[k*BLK-1 -: L]} + {1'b0, r_b[k*BLK-1 -: L]}) >> L);
        // The exact carry into bit k*BLK is recovered from the exact sum bit.
        assign w_ec[k] = w_exact[k*BLK] ^ r_a[k*BLK] ^ r_b[k*BLK];
      end

      if (k == NBLK - 1) begin : g_top
        // Top block keeps its carry-out as the result MSB.
        assign w_approx[WIDTH:k*BLK] = {1'b0, r_a[k*BLK +: BLK]}
                                     + {1'b0, r_b[k*BLK +: BLK]}
                                     + {{BLK{1'b0}}, w_pc[k]};
      end else begin : g_mid
        assign w_approx[k*BLK +: BLK] = BLK'(r_a[k*BLK +: BLK]
                                           + r_b[k*BLK +: BLK]
                                           + {{(BLK-1){1'b0}}, w_pc[k]});
      end
    end
  endgenerate

  assign w_mask = w_pc[NBLK-1:1] ^ w_ec;
  assign w_err  = |w_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= 1'b0;
      r_sum      <= '0;
      r_err      <= 1'b0;
      r_err_mask <= '0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is registered, so the first idle cycle after reset
          // only raises it; capture waits for a visible handshake.
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_mode     <= bus.mode;
            r_in_ready <= 1'b0;
            r_state    <= S_EVAL;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_EVAL: begin
          r_sum      <= w_approx;
          r_err      <= w_err;
          r_err_mask <= w_mask;
          r_state    <= (r_mode && w_err) ? S_CORR : S_HOLD;
        end
        S_CORR: begin
          // err/err_mask keep describing the speculation, only sum changes.
          r_sum   <= w_exact;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            if (r_err && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.sum       = r_sum;
  assign bus.err       = r_err;
  assign bus.err_mask  = r_err_mask;
  assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bcsa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcsa_pipe
// Description : Directed self-checking bench for bcsa_pipe (16-bit, 4-bit
//               blocks, 4-bit lookback, 4-bit error counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcsa_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcsa_pipe_if #(.WIDTH(16), .BLK(4), .CNT_W(4)) bus ();

  bcsa_pipe #(.WIDTH(16), .BLK(4), .LOOK(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; stall = HOLD cycles with out_ready low.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic tm,
                         input int exp_lat, input logic [16:0] exp_sum,
                         input logic exp_err, input logic [2:0] exp_mask, input int stall);
    int n;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_before", 32'(bus.in_ready), 32'd1);
    bus.a         = ta;
    bus.b         = tb_v;
    bus.mode      = tm;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.mode     = ~tm;
    check("ready_busy", 32'(bus.in_ready), 32'd0);
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("sum", 32'(bus.sum), 32'(exp_sum));
    check("err", 32'(bus.err), 32'(exp_err));
    check("err_mask", 32'(bus.err_mask), 32'(exp_mask));
    check("ready_hold", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_sum", 32'(bus.sum), 32'(exp_sum));
      check("stall_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (exp_err && exp_cnt < 15) exp_cnt++;
    check("valid_after", 32'(bus.out_valid), 32'd0);
    check("ready_after", 32'(bus.in_ready), 32'd1);
    check("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h00FF;
    bus.b         = 16'h0001;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held for two edges with in_valid asserted.
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ready_release", 32'(bus.in_ready), 32'd1);
    check("valid_release", 32'(bus.out_valid), 32'd0);

    // No misprediction.
    run_txn(16'h000F, 16'h0001, 1'b0, 2, 17'h00010, 1'b0, 3'b000, 0);
    // Speculation wrong at block 2, approximate result.
    run_txn(16'h00FF, 16'h0001, 1'b0, 2, 17'h00000, 1'b1, 3'b010, 0);
    // Same operands, corrected.
    run_txn(16'h00FF, 16'h0001, 1'b1, 3, 17'h00100, 1'b1, 3'b010, 0);
    // Max operands, all predictions right, backpressure.
    run_txn(16'hFFFF, 16'hFFFF, 1'b1, 2, 17'h1FFFE, 1'b0, 3'b000, 5);
    // Misprediction at block 3, corrected.
    run_txn(16'h0FF0, 16'h0010, 1'b1, 3, 17'h01000, 1'b1, 3'b100, 0);
    // No carries anywhere.
    run_txn(16'h1234, 16'h1111, 1'b0, 2, 17'h02345, 1'b0, 3'b000, 0);

    // Reset while in CORR.
    bus.a         = 16'h00FF;
    bus.b         = 16'h0001;
    bus.mode      = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("corr_no_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    check("midrst_cnt", 32'(bus.err_cnt), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check("midrst_no_pulse", 32'(seen), 32'd0);
    check("midrst_idle", 32'(bus.in_ready), 32'd1);

    // 18 erroring transactions: counter must stop at 15.
    for (int i = 0; i < 18; i++) begin
      if (i % 2 == 0)
        run_txn(16'h00FF, 16'h0001, 1'b0, 2, 17'h00000, 1'b1, 3'b010, 0);
      else
        run_txn(16'h00FF, 16'h0001, 1'b1, 3, 17'h00100, 1'b1, 3'b010, 0);
    end
    check("sat_cnt", 32'(bus.err_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bcsa_pipe.md
Name: bcsa_pipe

Overview:
- Parametrised, registered block-based carry-speculative adder (BCSA), successor to the fixed 16-bit/4-bit-block combinational BCSA.
- Splits WIDTH operands into NBLK = WIDTH/BLK blocks; each block's carry-in is predicted from a LOOK-bit window directly below it, so blocks evaluate independently.
- Adds a valid/ready handshake, a run-time accuracy mode (approximate or exact-by-correction), per-boundary misprediction reporting and a saturating error counter.
- Sits in the approximate-arithmetic datapath where a producer/consumer need a flow-controlled adder with selectable accuracy.

Parameters:
- WIDTH, 16, operand width; must be a multiple of BLK and ≥ 2*BLK.
- BLK, 4, bits per carry block.
- LOOK, 4, lookback window for carry prediction; 1 ≤ LOOK ≤ WIDTH−BLK; clipped to k*BLK for block k.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- mode  in  1  0 = approximate result; 1 = exact (corrected) result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH+1  result, MSB = carry-out.
- err  out  1  speculative result differed from exact sum for this transaction.
- err_mask  out  NBLK−1  bit k−1 set if the predicted carry into block k was wrong.
- err_cnt  out  CNT_W  saturating count of completed transactions with err = 1.

Behaviour:
- Reset: on a clk edge with rst_n = 0, go to IDLE and clear all outputs to 0 (in_ready = 0 during reset, 1 in IDLE afterwards). Reset overrides any state, including mid-operation; the in-flight transaction is discarded and never presented.
- Carry prediction for block k ≥ 1: the carry-out of bits [k*BLK−L, k*BLK−1] with carry-in 0, where L = min(LOOK, k*BLK). Block 0 carry-in is 0.
- Approximate sum: each block adds with its predicted carry-in and internal ripple. sum[WIDTH] is the carry-out of the top block.
- Exact sum: the full (WIDTH+1)-bit a+b. The exact carry into block k is that of a+b.
- err_mask[k−1] = predicted carry into block k XOR exact carry into block k.
- err = OR of err_mask. No error implies approximate sum = exact sum.
- FSM states:
  - IDLE: in_ready = 1. If in_valid, capture a, b and mode, then go to EVAL.
  - EVAL: in_ready = 0. Compute and register the approximate sum, err_mask and err.
    - If mode = 1 and err = 1, go to CORR.
    - Otherwise go to HOLD, with sum = approximate sum.
  - CORR: in_ready = 0. Register sum = exact sum; keep err and err_mask from EVAL (they describe the speculation). Go to HOLD.
  - HOLD: out_valid = 1; sum, err and err_mask are stable. When out_ready = 1, return to IDLE, clear out_valid, and increment err_cnt if err = 1.
- err_cnt saturates at 2^CNT_W − 1; it is cleared only by reset.
- Latency: with the handshake on cycle 0, out_valid rises on cycle 2, or on cycle 3 when correcting.
- Exactly one transaction is outstanding at a time. in_valid outside IDLE is ignored, and the producer must hold it.
- out_ready while out_valid = 0 has no effect.
- Inputs a, b and mode may change freely after capture.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, sum = 0, err_cnt = 0. in_ready is 1 on the first cycle after release.
- No misprediction: a = 0x000F, b = 0x0001, mode = 0, out_ready = 1 -> on cycle 2, sum = 0x00010, err = 0, err_mask = 3'b000.
- Approximate with error: a = 0x00FF, b = 0x0001, mode = 0 -> on cycle 2, sum = 0x00000, err = 1, err_mask = 3'b010; err_cnt becomes 1 after acceptance.
- Corrected: same operands, mode = 1 -> on cycle 3, sum = 0x00100, err = 1, err_mask = 3'b010.
- Max values with backpressure: a = b = 0xFFFF, mode = 1, out_ready low for 5 cycles -> sum = 0x1FFFE held stable and out_valid = 1 throughout, err = 0, in_ready = 0 until acceptance; IDLE on the next cycle.
- Reset mid-operation, then saturation: assert rst_n = 0 in CORR -> IDLE, no out_valid pulse. Run 2^CNT_W + 2 erroring transactions (CNT_W = 4 build) -> err_cnt holds 15.
